triangle_setup: RTL and testbench

- Consumer stage directly downstream of the per-frame object buffer.
- Pops triangles in order through the buffer's read port (data, read strobe, read_end).
- Computes screen-clipped bounding box, three edge-function coefficients and signed doubled area for each triangle. Culls degenerate and off-screen triangles.
- Emits setup records to the rasterizer over a valid/ready handshake.

---
 rtl/triangle_setup_pkg.sv | 83 ++++++++
 rtl/triangle_setup_edge_coeff.sv | 21 ++
 rtl/triangle_setup.sv | 228 ++++++++++++++++++++++
 tb/tb_triangle_setup.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/triangle_setup_pkg.sv
// Shared types for the object buffer / triangle setup / rasterizer path.
// Object, setup-record and edge layouts plus small arithmetic helpers.
package triangle_setup_pkg;

   localparam int COORD_W   = 11;
   localparam int COLOR_W   = 24;
   localparam int DEPTH_W   = 16;
   localparam int EDGE_AB_W = COORD_W + 1;
   localparam int EDGE_C_W  = 2 * COORD_W + 1;
   localparam int AREA_W    = 2 * COORD_W + 2;

   typedef logic [COORD_W-1:0] coord_t;
   typedef logic [COLOR_W-1:0] color_t;

   typedef struct packed {
      coord_t x;
      coord_t y;
   } point_t;

   typedef struct packed {
      point_t               a;
      point_t               b;
      point_t               c;
      color_t               color;
      logic [DEPTH_W-1:0]   depth;
   } object_t;

   typedef struct packed {
      logic signed [EDGE_AB_W-1:0] a;
      logic signed [EDGE_AB_W-1:0] b;
      logic signed [EDGE_C_W-1:0]  c;
   } edge_t;

   typedef struct packed {
      coord_t min_x;
      coord_t min_y;
      coord_t max_x;
      coord_t max_y;
   } bbox_t;

   typedef struct packed {
      bbox_t                    bbox;
      edge_t [2:0]              edges;
      logic signed [AREA_W-1:0] area2;
      color_t                   color;
      logic [DEPTH_W-1:0]       depth;
   } setup_t;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_EDGE   = 3'd2,
      ST_PROD   = 3'd3,
      ST_DECIDE = 3'd4,
      ST_EMIT   = 3'd5,
      ST_DONE   = 3'd6
   } state_t;

   function automatic logic signed [EDGE_AB_W-1:0] sdiff(input coord_t p, input coord_t q);
      return $signed({1'b0, p}) - $signed({1'b0, q});
   endfunction

   function automatic coord_t min3(input coord_t p, input coord_t q, input coord_t r);
      coord_t m;
      m = (p < q) ? p : q;
      return (m < r) ? m : r;
   endfunction

   function automatic coord_t max3(input coord_t p, input coord_t q, input coord_t r);
      coord_t m;
      m = (p > q) ? p : q;
      return (m > r) ? m : r;
   endfunction

   function automatic edge_t edge_neg(input edge_t e);
      edge_t n;
      n.a = -e.a;
      n.b = -e.b;
      n.c = -e.c;
      return n;
   endfunction

endpackage

// File: rtl/triangle_setup_edge_coeff.sv
// Edge-function coefficients A, B, C for the directed edge p_j -> p_k.
module edge_coeff
   import triangle_setup_pkg::*;
(
   input  point_t p_j,
   input  point_t p_k,
   output edge_t  coef
);

   logic [2*COORD_W-1:0] prod_jk;
   logic [2*COORD_W-1:0] prod_kj;

   always_comb begin
      prod_jk = {{COORD_W{1'b0}}, p_j.x} * {{COORD_W{1'b0}}, p_k.y};
      prod_kj = {{COORD_W{1'b0}}, p_k.x} * {{COORD_W{1'b0}}, p_j.y};
      coef.a  = sdiff(p_j.y, p_k.y);
      coef.b  = sdiff(p_k.x, p_j.x);
      coef.c  = $signed({1'b0, prod_jk}) - $signed({1'b0, prod_kj});
   end

endmodule

// File: rtl/triangle_setup.sv
// Triangle setup: pops objects, builds bbox/edge/area records, culls, hands off.
// Define TRIANGLE_SETUP_BACKFACE_CULL_EN to cull negative-area triangles instead of flipping them.
module triangle_setup
   import triangle_setup_pkg::*;
#(
   parameter int SCREEN_W = 640,
   parameter int SCREEN_H = 480,
   parameter int COUNT_W  = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               frame_start,
   input  object_t            obj_data,
   input  logic               obj_read_end,
   output logic               obj_read,
   output setup_t             setup_out,
   output logic               setup_valid,
   input  logic               setup_ready,
   output logic               frame_done,
   output logic               busy,
   output logic               overrun,
   output logic [COUNT_W-1:0] emitted_count,
   output logic [COUNT_W-1:0] culled_count
);

   // state  | meaning
   // IDLE   | waiting for frame_start
   // FETCH  | pop next object, or finish frame when list is exhausted
   // EDGE   | register A/B, vertex deltas, raw bbox
   // PROD   | register C, area2, clipped bbox
   // DECIDE | cull or load setup record
   // EMIT   | hold record until rasterizer accepts it
   // DONE   | one-cycle frame_done

   localparam coord_t X_LIM = coord_t'(SCREEN_W);
   localparam coord_t Y_LIM = coord_t'(SCREEN_H);
   localparam coord_t X_MAX = coord_t'(SCREEN_W - 1);
   localparam coord_t Y_MAX = coord_t'(SCREEN_H - 1);
   localparam logic [COUNT_W-1:0] CNT_MAX = '1;

   state_t                      state_q, state_d;
   object_t                     obj_q, obj_d;
   edge_t [2:0]                 edge_q, edge_d;
   edge_t                       coef0_w, coef1_w, coef2_w;
   logic signed [EDGE_AB_W-1:0] dx1_q, dx1_d, dy1_q, dy1_d;
   logic signed [EDGE_AB_W-1:0] dx2_q, dx2_d, dy2_q, dy2_d;
   logic signed [AREA_W-1:0]    area2_q, area2_d;
   bbox_t                       raw_q, raw_d, clip_q, clip_d;
   setup_t                      setup_q, setup_d, rec_w;
   logic                        valid_q, valid_d;
   logic                        done_q, done_d;
   logic                        overrun_q, overrun_d;
   logic [COUNT_W-1:0]          emitted_q, emitted_d, culled_q, culled_d;
   logic                        cull_w;

   edge_coeff u_edge_ab (.p_j(obj_q.a), .p_k(obj_q.b), .coef(coef0_w));
   edge_coeff u_edge_bc (.p_j(obj_q.b), .p_k(obj_q.c), .coef(coef1_w));
   edge_coeff u_edge_ca (.p_j(obj_q.c), .p_k(obj_q.a), .coef(coef2_w));

   always_comb begin
      rec_w       = '0;
      rec_w.bbox  = clip_q;
      rec_w.edges = edge_q;
      rec_w.area2 = area2_q;
      rec_w.color = obj_q.color;
      rec_w.depth = obj_q.depth;
      cull_w = (area2_q == '0) || (raw_q.min_x >= X_LIM) || (raw_q.min_y >= Y_LIM);
`ifdef TRIANGLE_SETUP_BACKFACE_CULL_EN
      if (area2_q[AREA_W-1]) cull_w = 1'b1;
`else
      // Swapping b and c reverses every edge: a->c = -(c->a), c->b = -(b->c), b->a = -(a->b)
      if (area2_q[AREA_W-1]) begin
         rec_w.edges[0] = edge_neg(edge_q[2]);
         rec_w.edges[1] = edge_neg(edge_q[1]);
         rec_w.edges[2] = edge_neg(edge_q[0]);
         rec_w.area2    = -area2_q;
      end
`endif
   end

   always_comb begin
      state_d   = state_q;
      obj_d     = obj_q;
      edge_d    = edge_q;
      dx1_d     = dx1_q;
      dy1_d     = dy1_q;
      dx2_d     = dx2_q;
      dy2_d     = dy2_q;
      area2_d   = area2_q;
      raw_d     = raw_q;
      clip_d    = clip_q;
      setup_d   = setup_q;
      valid_d   = valid_q;
      done_d    = 1'b0;
      overrun_d = overrun_q;
      emitted_d = emitted_q;
      culled_d  = culled_q;

      case (state_q)
         ST_IDLE: begin
            if (frame_start) begin
               emitted_d = '0;
               culled_d  = '0;
               state_d   = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (obj_read_end) begin
               done_d  = 1'b1;
               state_d = ST_DONE;
            end else begin
               obj_d   = obj_data;
               state_d = ST_EDGE;
            end
         end
         ST_EDGE: begin
            edge_d[0].a  = coef0_w.a;
            edge_d[0].b  = coef0_w.b;
            edge_d[1].a  = coef1_w.a;
            edge_d[1].b  = coef1_w.b;
            edge_d[2].a  = coef2_w.a;
            edge_d[2].b  = coef2_w.b;
            dx1_d        = sdiff(obj_q.b.x, obj_q.a.x);
            dy1_d        = sdiff(obj_q.b.y, obj_q.a.y);
            dx2_d        = sdiff(obj_q.c.x, obj_q.a.x);
            dy2_d        = sdiff(obj_q.c.y, obj_q.a.y);
            raw_d.min_x  = min3(obj_q.a.x, obj_q.b.x, obj_q.c.x);
            raw_d.min_y  = min3(obj_q.a.y, obj_q.b.y, obj_q.c.y);
            raw_d.max_x  = max3(obj_q.a.x, obj_q.b.x, obj_q.c.x);
            raw_d.max_y  = max3(obj_q.a.y, obj_q.b.y, obj_q.c.y);
            state_d      = ST_PROD;
         end
         ST_PROD: begin
            edge_d[0].c  = coef0_w.c;
            edge_d[1].c  = coef1_w.c;
            edge_d[2].c  = coef2_w.c;
            area2_d      = AREA_W'(dx1_q) * AREA_W'(dy2_q) - AREA_W'(dx2_q) * AREA_W'(dy1_q);
            clip_d.min_x = (raw_q.min_x > X_MAX) ? X_MAX : raw_q.min_x;
            clip_d.min_y = (raw_q.min_y > Y_MAX) ? Y_MAX : raw_q.min_y;
            clip_d.max_x = (raw_q.max_x > X_MAX) ? X_MAX : raw_q.max_x;
            clip_d.max_y = (raw_q.max_y > Y_MAX) ? Y_MAX : raw_q.max_y;
            state_d      = ST_DECIDE;
         end
         ST_DECIDE: begin
            if (cull_w) begin
               culled_d = (culled_q == CNT_MAX) ? culled_q : culled_q + 1'b1;
               state_d  = ST_FETCH;
            end else begin
               setup_d  = rec_w;
               valid_d  = 1'b1;
               state_d  = ST_EMIT;
            end
         end
         ST_EMIT: begin
            if (setup_ready) begin
               emitted_d = (emitted_q == CNT_MAX) ? emitted_q : emitted_q + 1'b1;
               valid_d   = 1'b0;
               state_d   = ST_FETCH;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A new frame pre-empts whatever is in flight; only DONE is a legal handover point
      if (frame_start && (state_q != ST_IDLE)) begin
         if (state_q != ST_DONE) overrun_d = 1'b1;
         valid_d   = 1'b0;
         done_d    = 1'b0;
         emitted_d = '0;
         culled_d  = '0;
         state_d   = ST_FETCH;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         obj_q     <= '0;
         edge_q    <= '0;
         dx1_q     <= '0;
         dy1_q     <= '0;
         dx2_q     <= '0;
         dy2_q     <= '0;
         area2_q   <= '0;
         raw_q     <= '0;
         clip_q    <= '0;
         setup_q   <= '0;
         valid_q   <= 1'b0;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
         emitted_q <= '0;
         culled_q  <= '0;
      end else begin
         state_q   <= state_d;
         obj_q     <= obj_d;
         edge_q    <= edge_d;
         dx1_q     <= dx1_d;
         dy1_q     <= dy1_d;
         dx2_q     <= dx2_d;
         dy2_q     <= dy2_d;
         area2_q   <= area2_d;
         raw_q     <= raw_d;
         clip_q    <= clip_d;
         setup_q   <= setup_d;
         valid_q   <= valid_d;
         done_q    <= done_d;
         overrun_q <= overrun_d;
         emitted_q <= emitted_d;
         culled_q  <= culled_d;
      end
   end

   // The pop must coincide with the cycle the slot is latched, so it cannot be registered
   assign obj_read      = (state_q == ST_FETCH) && !obj_read_end && !frame_start && !reset;
   assign setup_out     = setup_q;
   assign setup_valid   = valid_q;
   assign frame_done    = done_q;
   assign busy          = (state_q != ST_IDLE);
   assign overrun       = overrun_q;
   assign emitted_count = emitted_q;
   assign culled_count  = culled_q;

endmodule

// File: tb/tb_triangle_setup.sv
// Directed self-checking bench for triangle_setup with a simple object-buffer model.
module tb_triangle_setup;
   import triangle_setup_pkg::*;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       frame_start = 1'b0;
   logic       setup_ready = 1'b0;
   object_t    obj_data;
   logic       obj_read_end;
   logic       obj_read;
   setup_t     setup_out;
   logic       setup_valid;
   logic       frame_done;
   logic       busy;
   logic       overrun;
   logic [7:0] emitted_count;
   logic [7:0] culled_count;

   object_t objs [8];
   int      nobj = 0;
   int      rd_idx = 0;
   int      cyc = 0;
   int      checks = 0;
   int      errors = 0;
   setup_t  recs [$];
   int      valid_cycles = 0;
   int      done_seen = 0;
   int      done_cyc = 0;
   int      read_pulses = 0;

   triangle_setup #(.SCREEN_W(640), .SCREEN_H(480), .COUNT_W(8)) dut (
      .clock(clock), .reset(reset), .frame_start(frame_start),
      .obj_data(obj_data), .obj_read_end(obj_read_end), .obj_read(obj_read),
      .setup_out(setup_out), .setup_valid(setup_valid), .setup_ready(setup_ready),
      .frame_done(frame_done), .busy(busy), .overrun(overrun),
      .emitted_count(emitted_count), .culled_count(culled_count)
   );

   always #5 clock = ~clock;

   assign obj_read_end = (rd_idx >= nobj);
   assign obj_data     = (rd_idx < nobj) ? objs[rd_idx[2:0]] : '0;

   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (frame_start) rd_idx <= 0;
      else if (obj_read) rd_idx <= rd_idx + 1;
   end

   always @(negedge clock) begin
      if (setup_valid) valid_cycles++;
      if (setup_valid && setup_ready) recs.push_back(setup_out);
      if (frame_done) begin
         done_seen++;
         done_cyc = cyc;
      end
      if (obj_read) read_pulses++;
   end

   function automatic object_t mk_obj(input int ax, input int ay, input int bx, input int by,
                                      input int cx, input int cy, input int col, input int dep);
      object_t o;
      o.a.x = coord_t'(ax); o.a.y = coord_t'(ay);
      o.b.x = coord_t'(bx); o.b.y = coord_t'(by);
      o.c.x = coord_t'(cx); o.c.y = coord_t'(cy);
      o.color = color_t'(col);
      o.depth = DEPTH_W'(dep);
      return o;
   endfunction

   function automatic edge_t mk_edge(input int a, input int b, input int c);
      edge_t e;
      e.a = EDGE_AB_W'(a);
      e.b = EDGE_AB_W'(b);
      e.c = EDGE_C_W'(c);
      return e;
   endfunction

   function automatic setup_t mk_setup(input int x0, input int y0, input int x1, input int y1,
                                       input edge_t e0, input edge_t e1, input edge_t e2,
                                       input int ar, input int col, input int dep);
      setup_t s;
      s.bbox.min_x = coord_t'(x0); s.bbox.min_y = coord_t'(y0);
      s.bbox.max_x = coord_t'(x1); s.bbox.max_y = coord_t'(y1);
      s.edges[0] = e0; s.edges[1] = e1; s.edges[2] = e2;
      s.area2 = AREA_W'(ar);
      s.color = color_t'(col);
      s.depth = DEPTH_W'(dep);
      return s;
   endfunction

   function automatic setup_t tri1_rec(input int col, input int dep);
      return mk_setup(10, 10, 100, 75, mk_edge(-5, 90, -850), mk_edge(-60, -50, 6750),
                      mk_edge(65, -40, -250), 5650, col, dep);
   endfunction

   task automatic prep(input int n);
      recs.delete();
      valid_cycles = 0;
      done_seen    = 0;
      read_pulses  = 0;
      nobj         = n;
   endtask

   task automatic start_frame(output int fs_cyc);
      @(posedge clock); #1;
      frame_start = 1'b1;
      fs_cyc = cyc;
      @(posedge clock); #1;
      frame_start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int n = 0;
      while (done_seen == 0 && n < budget) begin
         @(negedge clock);
         n++;
      end
      @(negedge clock);
      checks++;
      if (done_seen == 0) begin
         errors++;
         $display("FAIL %s frame_done timeout got 0 exp 1", name);
      end
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (setup_valid !== 1'b1 && n < 30) begin
         @(negedge clock);
         n++;
      end
      checks++;
      if (setup_valid !== 1'b1) begin
         errors++;
         $display("FAIL %s setup_valid timeout got %b exp 1", name, setup_valid);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      checks++; if (setup_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", setup_valid); end
      checks++; if (setup_out !== '0) begin errors++; $display("FAIL rst_setup_out got %h exp 0", setup_out); end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", frame_done); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun got %b exp 0", overrun); end
      checks++; if (emitted_count !== 8'd0) begin errors++; $display("FAIL rst_emitted got %0d exp 0", emitted_count); end
      checks++; if (culled_count !== 8'd0) begin errors++; $display("FAIL rst_culled got %0d exp 0", culled_count); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
      checks++; if (obj_read !== 1'b0) begin errors++; $display("FAIL rst_obj_read got %b exp 0", obj_read); end
      @(posedge clock); #1;
      reset = 1'b0;
   endtask

   task automatic test_basic;
      int fs;
      setup_t exp_r, got;
      prep(1);
      objs[0] = mk_obj(10, 10, 100, 15, 50, 75, 'h123456, 'h0abc);
      exp_r = tri1_rec('h123456, 'h0abc);
      setup_ready = 1'b1;
      start_frame(fs);
      wait_done("basic", 40);
      got = (recs.size() > 0) ? recs[0] : '0;
      checks++; if (recs.size() != 1) begin errors++; $display("FAIL basic_nrec got %0d exp 1", recs.size()); end
      checks++; if (got !== exp_r) begin errors++; $display("FAIL basic_rec got %h exp %h", got, exp_r); end
      checks++; if (valid_cycles != 1) begin errors++; $display("FAIL basic_valid_cycles got %0d exp 1", valid_cycles); end
      checks++; if (emitted_count !== 8'd1) begin errors++; $display("FAIL basic_emitted got %0d exp 1", emitted_count); end
      checks++; if (culled_count !== 8'd0) begin errors++; $display("FAIL basic_culled got %0d exp 0", culled_count); end
   endtask

   task automatic test_collinear;
      int fs;
      prep(1);
      objs[0] = mk_obj(0, 0, 5, 5, 10, 10, 'h0000ff, 'h0002);
      setup_ready = 1'b1;
      start_frame(fs);
      wait_done("collinear", 40);
      checks++; if (valid_cycles != 0) begin errors++; $display("FAIL coll_valid got %0d exp 0", valid_cycles); end
      checks++; if (culled_count !== 8'd1) begin errors++; $display("FAIL coll_culled got %0d exp 1", culled_count); end
      checks++; if (emitted_count !== 8'd0) begin errors++; $display("FAIL coll_emitted got %0d exp 0", emitted_count); end
   endtask

   task automatic test_offscreen_clip;
      int fs;
      setup_t exp_r, got;
      prep(2);
      objs[0] = mk_obj(700, 10, 800, 10, 750, 50, 'h111111, 'h0003);
      objs[1] = mk_obj(600, 400, 700, 400, 600, 500, 'h222222, 'h0004);
      exp_r = mk_setup(600, 400, 639, 479, mk_edge(0, 100, -40000), mk_edge(-100, -100, 110000),
                       mk_edge(100, 0, -60000), 10000, 'h222222, 'h0004);
      setup_ready = 1'b1;
      start_frame(fs);
      wait_done("offscreen", 60);
      got = (recs.size() > 0) ? recs[0] : '0;
      checks++; if (recs.size() != 1) begin errors++; $display("FAIL clip_nrec got %0d exp 1", recs.size()); end
      checks++; if (got !== exp_r) begin errors++; $display("FAIL clip_rec got %h exp %h", got, exp_r); end
      checks++; if (culled_count !== 8'd1) begin errors++; $display("FAIL off_culled got %0d exp 1", culled_count); end
      checks++; if (emitted_count !== 8'd1) begin errors++; $display("FAIL clip_emitted got %0d exp 1", emitted_count); end
      checks++; if (read_pulses != 2) begin errors++; $display("FAIL clip_reads got %0d exp 2", read_pulses); end
   endtask

   task automatic test_winding;
      int fs;
      setup_t exp_r, got;
      prep(1);
      objs[0] = mk_obj(10, 10, 50, 75, 100, 15, 'h00ff00, 'h0001);
      exp_r = tri1_rec('h00ff00, 'h0001);
      setup_ready = 1'b1;
      start_frame(fs);
      wait_done("winding", 40);
      got = (recs.size() > 0) ? recs[0] : '0;
`ifdef TRIANGLE_SETUP_BACKFACE_CULL_EN
      checks++; if (recs.size() != 0) begin errors++; $display("FAIL cw_nrec got %0d exp 0", recs.size()); end
      checks++; if (culled_count !== 8'd1) begin errors++; $display("FAIL cw_culled got %0d exp 1", culled_count); end
`else
      checks++; if (got !== exp_r) begin errors++; $display("FAIL cw_rec got %h exp %h", got, exp_r); end
      checks++; if (emitted_count !== 8'd1) begin errors++; $display("FAIL cw_emitted got %0d exp 1", emitted_count); end
`endif
   endtask

   task automatic test_stall;
      int fs;
      setup_t exp_r, got;
      prep(1);
      objs[0] = mk_obj(10, 10, 100, 15, 50, 75, 'h123456, 'h0abc);
      exp_r = tri1_rec('h123456, 'h0abc);
      setup_ready = 1'b0;
      start_frame(fs);
      wait_valid("stall");
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         checks++; if (setup_out !== exp_r) begin errors++; $display("FAIL stall_hold[%0d] got %h exp %h", i, setup_out, exp_r); end
         checks++; if (setup_valid !== 1'b1 || obj_read !== 1'b0 || emitted_count !== 8'd0) begin
            errors++;
            $display("FAIL stall_ctl[%0d] got v=%b rd=%b cnt=%0d exp v=1 rd=0 cnt=0", i, setup_valid, obj_read, emitted_count);
         end
      end
      @(posedge clock); #1;
      setup_ready = 1'b1;
      wait_done("stall", 40);
      got = (recs.size() > 0) ? recs[0] : '0;
      checks++; if (emitted_count !== 8'd1) begin errors++; $display("FAIL stall_emitted got %0d exp 1", emitted_count); end
      checks++; if (got !== exp_r) begin errors++; $display("FAIL stall_rec got %h exp %h", got, exp_r); end
   endtask

   task automatic test_empty;
      int fs;
      prep(0);
      setup_ready = 1'b1;
      start_frame(fs);
      wait_done("empty", 20);
      checks++; if (done_cyc - fs != 2) begin errors++; $display("FAIL empty_latency got %0d exp 2", done_cyc - fs); end
      checks++; if (done_seen != 1) begin errors++; $display("FAIL empty_done_pulses got %0d exp 1", done_seen); end
      checks++; if (read_pulses != 0) begin errors++; $display("FAIL empty_reads got %0d exp 0", read_pulses); end
   endtask

   task automatic test_done_restart;
      int fs;
      int n = 0;
      prep(0);
      start_frame(fs);
      @(posedge clock); #1;
      frame_start = 1'b1;
      checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL restart_align got %b exp 1", frame_done); end
      @(posedge clock); #1;
      frame_start = 1'b0;
      while (done_seen < 2 && n < 20) begin
         @(negedge clock);
         n++;
      end
      checks++; if (done_seen != 2) begin errors++; $display("FAIL restart_done got %0d exp 2", done_seen); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL restart_overrun got %b exp 0", overrun); end
   endtask

   task automatic test_overrun;
      int fs;
      setup_t exp_r, got;
      prep(2);
      objs[0] = mk_obj(0, 0, 5, 5, 10, 10, 'h0000ff, 'h0002);
      objs[1] = mk_obj(10, 10, 100, 15, 50, 75, 'h123456, 'h0abc);
      exp_r = tri1_rec('h123456, 'h0abc);
      setup_ready = 1'b0;
      start_frame(fs);
      wait_valid("overrun");
      checks++; if (culled_count !== 8'd1) begin errors++; $display("FAIL ovr_pre_culled got %0d exp 1", culled_count); end
      start_frame(fs);
      @(negedge clock);
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b exp 1", overrun); end
      checks++; if (setup_valid !== 1'b0) begin errors++; $display("FAIL ovr_valid got %b exp 0", setup_valid); end
      checks++; if (culled_count !== 8'd0) begin errors++; $display("FAIL ovr_clear got %0d exp 0", culled_count); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ovr_busy got %b exp 1", busy); end
      setup_ready = 1'b1;
      wait_done("overrun", 60);
      got = (recs.size() > 0) ? recs[0] : '0;
      checks++; if (recs.size() != 1) begin errors++; $display("FAIL ovr_nrec got %0d exp 1", recs.size()); end
      checks++; if (got !== exp_r) begin errors++; $display("FAIL ovr_rec got %h exp %h", got, exp_r); end
      checks++; if (emitted_count !== 8'd1 || culled_count !== 8'd1) begin
         errors++;
         $display("FAIL ovr_counts got e=%0d c=%0d exp e=1 c=1", emitted_count, culled_count);
      end
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b exp 1", overrun); end
   endtask

   task automatic test_reset_mid;
      int fs;
      prep(1);
      objs[0] = mk_obj(10, 10, 100, 15, 50, 75, 'h123456, 'h0abc);
      setup_ready = 1'b0;
      start_frame(fs);
      reset = 1'b1;
      @(negedge clock);
      checks++; if (obj_read !== 1'b0) begin errors++; $display("FAIL rmid_read got %b exp 0", obj_read); end
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", busy); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rmid_overrun got %b exp 0", overrun); end
      checks++; if (setup_valid !== 1'b0 || setup_out !== '0) begin
         errors++;
         $display("FAIL rmid_out got v=%b out=%h exp v=0 out=0", setup_valid, setup_out);
      end
      checks++; if (read_pulses != 0) begin errors++; $display("FAIL rmid_reads got %0d exp 0", read_pulses); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_collinear();
      test_offscreen_clip();
      test_winding();
      test_stall();
      test_empty();
      test_done_restart();
      test_overrun();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
